// File: rtl/dmem_mmio.sv
// rtl/dmem_mmio.sv - data RAM with memory-mapped input, output and status registers
// Inputs are double-synchronised with sticky change flags; outputs are registered with write strobes.
module dmem_mmio #(
  parameter int W       = 8,
  parameter int AW      = 8,
  parameter int N_IN    = 3,
  parameter int N_OUT   = 4,
  parameter int IO_BASE = 'hF0
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [AW-1:0]        ADDR,
  input  logic [W-1:0]         DATA,
  input  logic                 MW,
  output logic [W-1:0]         Q,
  input  logic [N_IN*W-1:0]    IN_PORTS,
  output logic [N_OUT*W-1:0]   OUT_PORTS,
  output logic [N_OUT-1:0]     OUT_STB
);

  localparam logic [AW-1:0] RAM_TOP = AW'(IO_BASE);
  localparam logic [AW-1:0] STAT_A  = AW'(IO_BASE + N_IN + N_OUT);

  logic [W-1:0] mem [IO_BASE];

  logic [W-1:0] sync1 [N_IN];
  logic [W-1:0] sync2 [N_IN];
  logic [W-1:0] prev  [N_IN];
  logic [N_IN-1:0] flag;

  logic [W-1:0] out_reg [N_OUT];
  logic [N_OUT-1:0] stb_reg;

  logic              is_ram;
  logic [N_IN-1:0]   in_sel;
  logic [N_OUT-1:0]  out_sel;
  logic              stat_sel;
  logic              wr;

  // Address decode: every IO register owns exactly one address, no aliasing.
  always_comb begin
    in_sel  = '0;
    out_sel = '0;
    for (int i = 0; i < N_IN; i++) begin
      in_sel[i] = (ADDR == AW'(IO_BASE + i));
    end
    for (int j = 0; j < N_OUT; j++) begin
      out_sel[j] = (ADDR == AW'(IO_BASE + N_IN + j));
    end
  end

  assign is_ram   = (ADDR < RAM_TOP);
  assign stat_sel = (ADDR == STAT_A);
  assign wr       = MW && !RESET;

  // Zero-latency read path; unmapped IO addresses fall through to 0.
  always_comb begin
    Q = '0;
    if (is_ram) begin
      Q = mem[ADDR];
    end
    for (int i = 0; i < N_IN; i++) begin
      if (in_sel[i]) Q = sync2[i];
    end
    for (int j = 0; j < N_OUT; j++) begin
      if (out_sel[j]) Q = out_reg[j];
    end
    if (stat_sel) begin
      Q[N_IN-1:0] = flag;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr && is_ram) begin
      mem[ADDR] <= DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < N_IN; i++) begin
        sync1[i] <= '0;
        sync2[i] <= '0;
        prev[i]  <= '0;
      end
      flag <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        sync1[i] <= IN_PORTS[i*W +: W];
        sync2[i] <= sync1[i];
        prev[i]  <= sync2[i];
        // A detected change beats a same-edge write-1-to-clear.
        if (sync2[i] != prev[i]) begin
          flag[i] <= 1'b1;
        end else if (wr && stat_sel && DATA[i]) begin
          flag[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int j = 0; j < N_OUT; j++) begin
        out_reg[j] <= '0;
      end
      stb_reg <= '0;
    end else begin
      for (int j = 0; j < N_OUT; j++) begin
        if (wr && out_sel[j]) begin
          out_reg[j] <= DATA;
        end
      end
      stb_reg <= wr ? out_sel : '0;
    end
  end

  genvar gj;
  generate
    for (gj = 0; gj < N_OUT; gj++) begin : g_out
      assign OUT_PORTS[gj*W +: W] = out_reg[gj];
    end
  endgenerate

  assign OUT_STB = stb_reg;

endmodule
